// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants for pipe_stage_chain: default geometry, NOP payload, CPU stage depths.
// No logic; sizing helper for the occupancy counter.
// Consumers import this package; no flow-control behaviour lives here.
package pipe_stage_chain_pkg;

    localparam int unsigned PIPE_DEF_WIDTH = 32;
    localparam int unsigned PIPE_DEF_DEPTH = 2;

    // RISC-V "addi x0,x0,0": lets a reset or cleared stage read as a harmless instruction.
    localparam logic [31:0] PIPE_NOP_INST = 32'h0000_0013;

    localparam int unsigned PIPE_IF_ID_DEPTH  = 1;
    localparam int unsigned PIPE_ID_EX_DEPTH  = 1;
    localparam int unsigned PIPE_EX_MEM_DEPTH = 1;
    localparam int unsigned PIPE_MEM_WB_DEPTH = 1;

    function automatic int unsigned pipe_cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_stage_chain_cell.sv
// One pipeline stage: valid bit + payload register, ready chain, flush and stall.
// Latency 1 cycle from up_vld/up_dat to vld/dat.
// Ready when empty or when downstream is ready; flush beats stall beats move/hold.
module pipe_stage_chain_cell
    import pipe_stage_chain_pkg::*;
#(
    parameter int unsigned     WIDTH   = PIPE_DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             up_vld,
    input  logic [WIDTH-1:0] up_dat,
    input  logic             dn_rdy,
    output logic             vld,
    output logic [WIDTH-1:0] dat,
    output logic             rdy,
    output logic             vld_nxt
);

    assign rdy = ~vld | dn_rdy;

    always_comb begin
        vld_nxt = vld;
        if (flush) begin
            vld_nxt = 1'b0;
        end else if (!stall && rdy) begin
            vld_nxt = up_vld;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
            dat <= RST_VAL;
        end else begin
            vld <= vld_nxt;
`ifdef PIPE_STAGE_CLEAR_DATA_EN
            // Bubbles read as RST_VAL so downstream decoders see a NOP.
            if (flush) begin
                dat <= RST_VAL;
            end else if (!stall && rdy) begin
                dat <= up_vld ? up_dat : RST_VAL;
            end
`else
            if (!flush && !stall && rdy && up_vld) begin
                dat <= up_dat;
            end
`endif
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready register chain with bubble collapse, per-stage flush, occupancy count.
// Latency DEPTH cycles into an empty chain, throughput 1 item/clk; optional PIPE_STAGE_CLEAR_DATA_EN.
// in_ready drops only when every stage is occupied and out_ready=0, or under stall_i.
module pipe_stage_chain
    import pipe_stage_chain_pkg::*;
#(
    parameter int unsigned      WIDTH   = PIPE_DEF_WIDTH,
    parameter int unsigned      DEPTH   = PIPE_DEF_DEPTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall_i,
    input  logic [DEPTH-1:0]           flush_i,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned CNT_W = pipe_cnt_w(DEPTH);

    logic [DEPTH:0]   rdy;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [WIDTH-1:0] dat [DEPTH];
    logic [CNT_W-1:0] cnt_nxt;

    assign rdy[DEPTH] = out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_vld;
        logic [WIDTH-1:0] up_dat;

        if (k == 0) begin : g_head
            assign up_vld = in_valid;
            assign up_dat = in_data;
        end else begin : g_body
            // A flushed item must not survive by moving on in the same cycle.
            assign up_vld = vld[k-1] & ~flush_i[k-1];
            assign up_dat = dat[k-1];
        end

        pipe_stage_chain_cell #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .stall   (stall_i),
            .flush   (flush_i[k]),
            .up_vld  (up_vld),
            .up_dat  (up_dat),
            .dn_rdy  (rdy[k+1]),
            .vld     (vld[k]),
            .dat     (dat[k]),
            .rdy     (rdy[k]),
            .vld_nxt (vld_nxt[k])
        );
    end

    assign in_ready  = rdy[0] & ~stall_i;
    assign out_valid = vld[DEPTH-1] & ~flush_i[DEPTH-1] & ~stall_i;
    assign out_data  = dat[DEPTH-1];

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(vld_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_o <= '0;
        end else begin
            count_o <= cnt_nxt;
        end
    end

endmodule
